buzzer_tone_gen: RTL

//   Square-wave tone generator driving the piezo buzzer pin. Consumes the note stream
//   (enable + freq in Hz) produced by the melody sequencer and converts it into a

---
 rtl/buzzer_tone_gen.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen
//   Square-wave PWM generator for the piezo buzzer. A legal note request
//   (enable=1, MIN_FREQ <= freq <= MAX_FREQ) is latched, its period and
//   high-time are computed by one shared 1-bit-per-cycle restoring divider,
//   and the result is staged as a pending waveform. The pending waveform
//   starts at once if nothing is playing, otherwise at the next period wrap,
//   so a running period is never truncated or stretched.
//
// State table
//   IDLE  | no computation in progress (silent, or nothing left to do)
//   DIV_P | period = floor(CLK_HZ / freq_q), 32 divider steps
//   DIV_H | high   = floor(period * DUTY_PCT / 100), 32 divider steps
//   LOAD  | stage period/high as the pending waveform
//   RUN   | pending staged or applied; waveform runs until a new request
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = play tone at freq, 0 = silence
//   freq         in   requested tone frequency in Hz
//   buzzer_out   out  registered PWM output
//   tone_active  out  1 while a valid waveform is being generated
module buzzer_tone_gen #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned DUTY_PCT = 70,
  parameter int unsigned FREQ_W   = 20,
  parameter int unsigned MIN_FREQ = 20,
  parameter int unsigned MAX_FREQ = 20_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [FREQ_W-1:0] freq,
  output logic              buzzer_out,
  output logic              tone_active
);

  typedef enum logic [2:0] {IDLE, DIV_P, DIV_H, LOAD, RUN} state_t;

  localparam logic [31:0] CLK_W  = 32'(CLK_HZ);
  localparam logic [31:0] DUTY_W = 32'(DUTY_PCT);

  state_t            state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [4:0]        div_cnt_q, div_cnt_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       period_calc_q, period_calc_d;
  logic [31:0]       pend_period_q, pend_period_d;
  logic [31:0]       pend_high_q, pend_high_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       period_q, period_d;
  logic [31:0]       high_q, high_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              tone_active_q, tone_active_d;
  logic              buzzer_q, buzzer_d;

  // Divider datapath: quo_q holds the remaining dividend bits and collects
  // quotient bits from the right; rem_q is the running remainder.
  logic [31:0] divisor;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] quo_next;
  logic [31:0] rem_next;
  logic [31:0] prod;

  assign divisor  = (state_q == DIV_H) ? 32'd100 : 32'(freq_q);
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign quo_next = {quo_q[30:0], q_bit};
  assign rem_next = q_bit ? diff[31:0] : shifted[31:0];
  assign prod     = quo_next * DUTY_W;

  logic legal;
  logic new_req;
  logic apply_ok;
  logic last_step;

  assign legal     = enable && (32'(freq) >= MIN_FREQ) && (32'(freq) <= MAX_FREQ);
  assign new_req   = legal && (freq != freq_q);
  // A newer request supersedes a staged-but-unapplied waveform.
  assign apply_ok  = pend_valid_q && !new_req;
  assign last_step = (div_cnt_q == 5'd31);

  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    div_cnt_d     = div_cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    period_calc_d = period_calc_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    pend_valid_d  = pend_valid_q;
    period_d      = period_q;
    high_d        = high_q;
    cnt_d         = cnt_q;
    tone_active_d = tone_active_q;
    buzzer_d      = tone_active_q && (cnt_q < high_q);

    // Waveform counter; pending values only take effect at a period wrap
    // or when nothing is currently playing.
    if (tone_active_q) begin
      if (cnt_q + 32'd1 == period_q) begin
        cnt_d = 32'd0;
        if (apply_ok) begin
          period_d     = pend_period_q;
          high_d       = pend_high_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else if (apply_ok) begin
      period_d      = pend_period_q;
      high_d        = pend_high_q;
      cnt_d         = 32'd0;
      tone_active_d = 1'b1;
      pend_valid_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: ;
      DIV_P: begin
        rem_d     = rem_next;
        quo_d     = quo_next;
        div_cnt_d = div_cnt_q + 5'd1;
        if (last_step) begin
          period_calc_d = quo_next;
          rem_d         = 32'd0;
          quo_d         = prod;
          div_cnt_d     = 5'd0;
          state_d       = DIV_H;
        end
      end
      DIV_H: begin
        rem_d     = rem_next;
        quo_d     = quo_next;
        div_cnt_d = div_cnt_q + 5'd1;
        if (last_step) begin
          div_cnt_d = 5'd0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        pend_period_d = period_calc_q;
        pend_high_d   = quo_q;
        pend_valid_d  = 1'b1;
        state_d       = RUN;
      end
      RUN: ;
      default: state_d = IDLE;
    endcase

    // New note: restart the division from scratch (latest request wins).
    if (new_req) begin
      freq_d       = freq;
      state_d      = DIV_P;
      rem_d        = 32'd0;
      quo_d        = CLK_W;
      div_cnt_d    = 5'd0;
      pend_valid_d = 1'b0;
    end

    // Disable or out-of-range request silences everything, overriding all.
    if (!legal) begin
      state_d       = IDLE;
      freq_d        = '0;
      div_cnt_d     = 5'd0;
      pend_valid_d  = 1'b0;
      cnt_d         = 32'd0;
      tone_active_d = 1'b0;
      buzzer_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      freq_q        <= '0;
      div_cnt_q     <= 5'd0;
      rem_q         <= 32'd0;
      quo_q         <= 32'd0;
      period_calc_q <= 32'd0;
      pend_period_q <= 32'd0;
      pend_high_q   <= 32'd0;
      pend_valid_q  <= 1'b0;
      period_q      <= 32'd0;
      high_q        <= 32'd0;
      cnt_q         <= 32'd0;
      tone_active_q <= 1'b0;
      buzzer_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      freq_q        <= freq_d;
      div_cnt_q     <= div_cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      period_calc_q <= period_calc_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      pend_valid_q  <= pend_valid_d;
      period_q      <= period_d;
      high_q        <= high_d;
      cnt_q         <= cnt_d;
      tone_active_q <= tone_active_d;
      buzzer_q      <= buzzer_d;
    end
  end

  assign buzzer_out  = buzzer_q;
  assign tone_active = tone_active_q;

endmodule
